// File: rtl/from_boot_loader.sv
// Boot-table loader: reads a byte-wide table from the FROM over one Wishbone master port
// and replays each 4-byte record as a 16-bit register write on a second master port.
module from_boot_loader #(
    parameter logic [15:0] FROM_BASE = 16'h0000,
    parameter logic [7:0]  MAGIC     = 8'hA5,
    parameter logic [15:0] TIMEOUT   = 16'd1023
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        restart,
    output logic        rd_cyc_o,
    output logic        rd_stb_o,
    output logic        rd_we_o,
    output logic [15:0] rd_adr_o,
    input  logic [15:0] rd_dat_i,
    input  logic        rd_ack_i,
    output logic        wr_cyc_o,
    output logic        wr_stb_o,
    output logic        wr_we_o,
    output logic [15:0] wr_adr_o,
    output logic [15:0] wr_dat_o,
    input  logic        wr_ack_i,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [1:0]  err_code,
    output logic [4:0]  rec_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_RD_REQ, S_RD_WAIT, S_PARSE, S_WR_REQ, S_WR_WAIT, S_DONE, S_ERROR
    } state_t;

    state_t      state_q, state_d;
    logic [6:0]  idx_q, idx_d;
    logic [4:0]  n_q, n_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [7:0]  byte_q, byte_d;
    logic [15:0] adr_q, adr_d;
    logic [15:0] dat_q, dat_d;
    logic [15:0] tmo_q, tmo_d;
    logic [1:0]  err_q, err_d;

    // Only the low byte of each FROM read carries table data.
    logic unused_rd_hi;
    assign unused_rd_hi = ^rd_dat_i[15:8];

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            state_q <= S_IDLE;
            idx_q   <= 7'd0;
            n_q     <= 5'd0;
            cnt_q   <= 5'd0;
            byte_q  <= 8'd0;
            adr_q   <= 16'd0;
            dat_q   <= 16'd0;
            tmo_q   <= 16'd0;
            err_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
            byte_q  <= byte_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        n_d     = n_q;
        cnt_d   = cnt_q;
        byte_d  = byte_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        tmo_d   = tmo_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                idx_d   = 7'd0;
                cnt_d   = 5'd0;
                err_d   = 2'd0;
                state_d = S_RD_REQ;
            end
            S_RD_REQ: begin
                tmo_d   = 16'd0;
                state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (rd_ack_i) begin
                    byte_d  = rd_dat_i[7:0];
                    state_d = S_PARSE;
                end else if (tmo_q >= TIMEOUT) begin
                    err_d   = 2'd3;
                    state_d = S_ERROR;
                end else if (tmo_q != 16'hFFFF) begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            S_PARSE: begin
                if (idx_q == 7'd0) begin
                    if (byte_q != MAGIC) begin
                        err_d   = 2'd1;
                        state_d = S_ERROR;
                    end else begin
                        idx_d   = idx_q + 7'd1;
                        state_d = S_RD_REQ;
                    end
                end else if (idx_q == 7'd1) begin
                    if (byte_q > 8'd31) begin
                        err_d   = 2'd2;
                        state_d = S_ERROR;
                    end else if (byte_q == 8'd0) begin
                        state_d = S_DONE;
                    end else begin
                        n_d     = byte_q[4:0];
                        idx_d   = idx_q + 7'd1;
                        state_d = S_RD_REQ;
                    end
                end else begin
                    // Record byte position is (idx-2) mod 4, i.e. idx[1:0] = 2,3,0,1.
                    case (idx_q[1:0])
                        2'd2:    adr_d = {byte_q, adr_q[7:0]};
                        2'd3:    adr_d = {adr_q[15:8], byte_q};
                        2'd0:    dat_d = {byte_q, dat_q[7:0]};
                        default: dat_d = {dat_q[15:8], byte_q};
                    endcase
                    if (idx_q[1:0] == 2'd1) begin
                        state_d = S_WR_REQ;
                    end else begin
                        idx_d   = idx_q + 7'd1;
                        state_d = S_RD_REQ;
                    end
                end
            end
            S_WR_REQ: begin
                tmo_d   = 16'd0;
                state_d = S_WR_WAIT;
            end
            S_WR_WAIT: begin
                if (wr_ack_i) begin
                    cnt_d = cnt_q + 5'd1;
                    if ((cnt_q + 5'd1) == n_q) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 7'd1;
                        state_d = S_RD_REQ;
                    end
                end else if (tmo_q >= TIMEOUT) begin
                    err_d   = 2'd3;
                    state_d = S_ERROR;
                end else if (tmo_q != 16'hFFFF) begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            S_DONE, S_ERROR: begin
                if (restart) begin
                    err_d   = 2'd0;
                    cnt_d   = 5'd0;
                    idx_d   = 7'd0;
                    state_d = S_RD_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign rd_cyc_o  = (state_q == S_RD_REQ);
    assign rd_stb_o  = (state_q == S_RD_REQ);
    assign rd_we_o   = 1'b0;
    assign rd_adr_o  = FROM_BASE + {9'd0, idx_q};
    assign wr_cyc_o  = (state_q == S_WR_REQ);
    assign wr_stb_o  = (state_q == S_WR_REQ);
    assign wr_we_o   = (state_q == S_WR_REQ);
    assign wr_adr_o  = adr_q;
    assign wr_dat_o  = dat_q;
    assign busy      = (state_q == S_RD_REQ) || (state_q == S_RD_WAIT) || (state_q == S_PARSE)
                    || (state_q == S_WR_REQ) || (state_q == S_WR_WAIT);
    assign done      = (state_q == S_DONE);
    assign error     = (state_q == S_ERROR);
    assign err_code  = err_q;
    assign rec_count = cnt_q;

endmodule

// File: tb/tb_from_boot_loader.sv
// Bench for from_boot_loader: FROM byte model, register-file write slave, table-level reference model.
module tb_from_boot_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        restart;
  logic        rd_cyc, rd_stb, rd_we, rd_ack;
  logic [15:0] rd_adr, rd_dat;
  logic        wr_cyc, wr_stb, wr_we, wr_ack;
  logic [15:0] wr_adr, wr_dat;
  logic        busy, done, error;
  logic [1:0]  err_code;
  logic [4:0]  rec_count;

  always #5 clk = ~clk;

  from_boot_loader dut (
    .wb_clk_i(clk), .wb_rst_i(rst_n), .restart(restart),
    .rd_cyc_o(rd_cyc), .rd_stb_o(rd_stb), .rd_we_o(rd_we), .rd_adr_o(rd_adr),
    .rd_dat_i(rd_dat), .rd_ack_i(rd_ack),
    .wr_cyc_o(wr_cyc), .wr_stb_o(wr_stb), .wr_we_o(wr_we), .wr_adr_o(wr_adr),
    .wr_dat_o(wr_dat), .wr_ack_i(wr_ack),
    .busy(busy), .done(done), .error(error), .err_code(err_code), .rec_count(rec_count)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0]  mem [128];
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  int          exp_reads;
  logic [1:0]  exp_code;
  logic        exp_done;
  int          exp_recs;

  int          n_rd, n_wr, overlap, bad_we;
  logic [15:0] first_rd_adr, last_rd_adr;
  bit          rd_pend, wr_pend, wr_noack;
  int          rd_dly, wr_dly, wr_dly_min, wr_dly_max;
  logic [6:0]  rd_a;

  // Slave models act on the falling edge; acks are therefore stable at the DUT's rising edge.
  always @(negedge clk) begin
    logic [7:0] hi;
    rd_ack = 1'b0;
    wr_ack = 1'b0;
    if (!rst_n) begin
      rd_pend = 1'b0;
      wr_pend = 1'b0;
    end
    if (rd_cyc && wr_cyc) overlap++;
    if (rd_stb && rd_we) bad_we++;
    if (wr_stb && !wr_we) bad_we++;
    if (rd_pend) begin
      if (rd_dly == 0) begin
        hi      = 8'($urandom_range(0, 255));
        rd_dat  = {hi, mem[rd_a]};
        rd_ack  = 1'b1;
        rd_pend = 1'b0;
      end else rd_dly--;
    end
    if (wr_pend) begin
      if (wr_dly == 0) begin
        wr_ack  = 1'b1;
        wr_pend = 1'b0;
      end else wr_dly--;
    end
    if (rd_stb) begin
      if (n_rd == 0) first_rd_adr = rd_adr;
      last_rd_adr = rd_adr;
      n_rd++;
      rd_a    = rd_adr[6:0];
      rd_dly  = $urandom_range(0, 3);
      rd_pend = 1'b1;
    end
    if (wr_stb) begin
      got_q.push_back({wr_adr, wr_dat});
      n_wr++;
      wr_dly  = $urandom_range(wr_dly_min, wr_dly_max);
      wr_pend = !wr_noack;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: derive the load outcome directly from the table contents.
  task automatic build_exp();
    int n;
    exp_q.delete();
    if (mem[0] != 8'hA5) begin
      exp_code = 2'd1; exp_done = 1'b0; exp_reads = 1; exp_recs = 0;
    end else begin
      n = int'(mem[1]);
      if (n > 31) begin
        exp_code = 2'd2; exp_done = 1'b0; exp_reads = 2; exp_recs = 0;
      end else begin
        exp_code = 2'd0; exp_done = 1'b1; exp_reads = 2 + 4 * n; exp_recs = n;
        for (int k = 0; k < n; k++)
          exp_q.push_back({mem[2+4*k], mem[3+4*k], mem[4+4*k], mem[5+4*k]});
      end
    end
  endtask

  task automatic clear_counts();
    n_rd = 0; n_wr = 0; got_q.delete();
  endtask

  task automatic pulse_restart();
    @(negedge clk); restart = 1'b1;
    @(negedge clk); restart = 1'b0;
  endtask

  task automatic start_load();
    build_exp();
    clear_counts();
    pulse_restart();
  endtask

  task automatic wait_end(input int max_cycles);
    int k = 0;
    while (!(done || error) && k < max_cycles) begin
      @(negedge clk); k++;
    end
    check("finish_in_time", 64'(done || error), 64'd1);
  endtask

  task automatic check_result(input string tag);
    check({tag, "_done"}, 64'(done), 64'(exp_done));
    check({tag, "_error"}, 64'(error), 64'(!exp_done));
    check({tag, "_code"}, 64'(err_code), 64'(exp_code));
    check({tag, "_recs"}, 64'(rec_count), 64'(exp_recs));
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_reads"}, 64'(n_rd), 64'(exp_reads));
    check({tag, "_writes"}, 64'(n_wr), 64'(exp_q.size()));
    while (got_q.size() > 0 && exp_q.size() > 0)
      check({tag, "_wr_data"}, 64'(got_q.pop_front()), 64'(exp_q.pop_front()));
  endtask

  task automatic random_table(input int n);
    for (int i = 0; i < 128; i++) mem[i] = 8'($urandom_range(0, 255));
    mem[0] = 8'hA5;
    mem[1] = 8'(n);
  endtask

  function automatic logic [63:0] all_outs();
    return {rd_cyc, rd_stb, rd_we, rd_adr, wr_cyc, wr_stb, wr_we, wr_adr, wr_dat,
            busy, done, error, err_code, rec_count};
  endfunction

  initial begin
    int k;
    int mode;
    restart = 1'b0; rst_n = 1'b0; rd_ack = 1'b0; wr_ack = 1'b0; rd_dat = 16'd0;
    overlap = 0; bad_we = 0; wr_noack = 1'b0; wr_dly_min = 0; wr_dly_max = 2;
    first_rd_adr = 16'd0; last_rd_adr = 16'd0;

    // Directed table: two records, loaded by the auto-start after reset.
    for (int i = 0; i < 128; i++) mem[i] = 8'h00;
    mem[0] = 8'hA5; mem[1] = 8'h02;
    mem[2] = 8'h00; mem[3] = 8'h10; mem[4] = 8'h12; mem[5] = 8'h34;
    mem[6] = 8'h00; mem[7] = 8'h11; mem[8] = 8'hAB; mem[9] = 8'hCD;
    build_exp();
    clear_counts();
    repeat (3) @(negedge clk);
    check("reset_outputs", all_outs(), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("start_busy", 64'(busy), 64'd1);
    check("start_stb", 64'(rd_stb), 64'd1);
    check("start_adr", 64'(rd_adr), 64'd0);
    wait_end(20000);
    check_result("two_rec");

    // Bad magic.
    mem[0] = 8'h5A;
    start_load(); wait_end(20000); check_result("bad_magic");

    // Count overflow, then the largest legal table.
    mem[0] = 8'hA5; mem[1] = 8'h20;
    start_load(); wait_end(20000); check_result("n32");
    random_table(31);
    start_load(); wait_end(20000); check_result("n31");
    check("n31_last_adr", 64'(last_rd_adr), 64'd125);

    // Write slave never acks: timeout on the first write, then a clean reload.
    random_table(3);
    wr_noack = 1'b1;
    start_load(); wait_end(5000);
    check("tmo_error", 64'(error), 64'd1);
    check("tmo_code", 64'(err_code), 64'd3);
    check("tmo_recs", 64'(rec_count), 64'd0);
    check("tmo_writes", 64'(n_wr), 64'd1);
    wr_noack = 1'b0;
    start_load(); wait_end(20000); check_result("tmo_reload");

    // Reset while waiting on the ack of record 1.
    random_table(3);
    wr_dly_min = 6; wr_dly_max = 6;
    start_load();
    k = 0;
    while (n_wr < 2 && k < 2000) begin @(negedge clk); k++; end
    check("mid_reached_rec1", 64'(n_wr), 64'd2);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_reset_outputs", all_outs(), 64'd0);
    repeat (3) @(negedge clk);
    check("mid_reset_quiet", 64'(n_wr), 64'd2);
    wr_dly_min = 0; wr_dly_max = 2;
    build_exp();
    clear_counts();
    rst_n = 1'b1;
    wait_end(20000);
    check_result("mid_reload");
    check("mid_first_adr", 64'(first_rd_adr), 64'd0);

    // Empty table, with a restart pulse while busy.
    mem[0] = 8'hA5; mem[1] = 8'h00;
    start_load();
    pulse_restart();
    wait_end(20000);
    repeat (5) @(negedge clk);
    check_result("empty");

    // Randomized tables, some corrupted, with stray restarts while busy.
    for (int it = 0; it < 6; it++) begin
      mode = $urandom_range(0, 7);
      random_table($urandom_range(0, 31));
      if (mode == 0) mem[0] = 8'hA5 ^ 8'($urandom_range(1, 255));
      if (mode == 1) mem[1] = 8'($urandom_range(32, 255));
      start_load();
      repeat ($urandom_range(0, 20)) @(negedge clk);
      if (busy) pulse_restart();
      wait_end(20000);
      check_result("rand");
    end

    check("no_overlap", 64'(overlap), 64'd0);
    check("we_levels", 64'(bad_we), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
